// File: rtl/bus_serial_tx.sv
// Serialises bus requests: LSB-first address phase, optional turnaround, LSB-first write-data phase.
// Define BUS_SERIAL_TX_PARITY_EN to append an even-parity bit to the write-data phase.
module bus_serial_tx #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  bus_data_out,
  output logic                  bus_data_out_valid,
  output logic                  bus_mode,
  output logic                  tx_done
);

  localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_NB = $clog2(MAX_W + 1);
  localparam int CNT_W  = (CNT_NB > 4) ? CNT_NB : 4;

  localparam int ADDR_LAST = ADDR_WIDTH - 1;
  localparam int TURN_LAST = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
`ifdef BUS_SERIAL_TX_PARITY_EN
  localparam int DATA_LAST = DATA_WIDTH;
`else
  localparam int DATA_LAST = DATA_WIDTH - 1;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_TURN = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  write_q;
  logic                  handshake;
`ifdef BUS_SERIAL_TX_PARITY_EN
  logic                  parity_q;
`endif

  assign handshake = req_valid && req_ready;

  always_comb begin
    // NOTE: default assignment first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE: if (handshake) next_state = S_ADDR;
      S_ADDR:
        if (cnt == CNT_W'(ADDR_LAST)) begin
          if (!write_q)              next_state = S_DONE;
          else if (TURN_CYCLES > 0)  next_state = S_TURN;
          else                       next_state = S_DATA;
        end
      S_TURN: if (cnt == CNT_W'(TURN_LAST)) next_state = S_DATA;
      S_DATA: if (cnt == CNT_W'(DATA_LAST)) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state     <= S_IDLE;
      req_ready <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == S_IDLE);
      // Counter restarts on every phase change so each phase counts from zero.
      if (next_state != state)
        cnt <= '0;
      else if (state == S_ADDR || state == S_TURN || state == S_DATA)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Captured request; shift registers present the current bit at position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sh  <= '0;
      data_sh  <= '0;
      write_q  <= 1'b0;
`ifdef BUS_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (handshake) begin
      addr_sh  <= req_addr;
      data_sh  <= req_wdata;
      write_q  <= req_write;
`ifdef BUS_SERIAL_TX_PARITY_EN
      parity_q <= ^req_wdata;
`endif
    end else begin
      if (state == S_ADDR) addr_sh <= addr_sh >> 1;
      if (state == S_DATA) data_sh <= data_sh >> 1;
    end
  end

  assign bus_data_out_valid = (state == S_ADDR) || (state == S_DATA);
  assign bus_mode           = (state == S_DATA);
  assign tx_done            = (state == S_DONE);

  always_comb begin
    bus_data_out = 1'b0;
    if (state == S_ADDR) begin
      bus_data_out = addr_sh[0];
    end else if (state == S_DATA) begin
`ifdef BUS_SERIAL_TX_PARITY_EN
      bus_data_out = (cnt == CNT_W'(DATA_WIDTH)) ? parity_q : data_sh[0];
`else
      bus_data_out = data_sh[0];
`endif
    end
  end

endmodule

// File: doc/bus_serial_tx.md
BUS_SERIAL_TX -- requirements
Module: bus_serial_tx

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, serial address length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, serial write-data length in bits.
REQ-003 SHALL have parameter TURN_CYCLES, default 1, idle cycles between address and data phases (range 0..15).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  initiator request present.
REQ-007 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  target address.
REQ-009 SHALL have port req_write  input  1  1 = write (data phase follows), 0 = read (address only).
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port bus_data_out  output  1  serial bit to bus.
REQ-012 SHALL have port bus_data_out_valid  output  1  bus_data_out carries a bit this cycle.
REQ-013 SHALL have port bus_mode  output  1  1 = data, 0 = address.
REQ-014 SHALL have port tx_done  output  1  one-cycle pulse, transaction fully sent.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, TURN, DATA, DONE.
REQ-016 req_ready SHALL be 1 only in IDLE; handshake = req_valid && req_ready; req_addr, req_write, req_wdata captured into internal registers on handshake, inputs ignored otherwise.
REQ-017 IDLE -> ADDR on handshake; first address bit appears on the cycle after the handshake (latency 1).
REQ-018 ADDR: bus_mode=0, bus_data_out_valid=1 for exactly ADDR_WIDTH consecutive cycles, LSB first (bit 0 first, bit ADDR_WIDTH-1 last); no gaps permitted.
REQ-019 After last address bit: read -> DONE; write -> TURN if TURN_CYCLES>0, else directly DATA.
REQ-020 TURN: bus_data_out_valid=0, bus_mode=0, bus_data_out=0 for exactly TURN_CYCLES cycles, then DATA.
REQ-021 DATA: bus_mode=1, bus_data_out_valid=1 for DATA_WIDTH consecutive cycles, LSB first, then DONE.
REQ-022 DONE: tx_done=1 for exactly one cycle, bus_data_out_valid=0, bus_mode=0; next state IDLE.
REQ-023 Whenever bus_data_out_valid=0, bus_data_out SHALL be 0.
REQ-024 Bit counter SHALL be wide enough for max(ADDR_WIDTH, DATA_WIDTH) and reset to 0 on every phase entry; no wrap-around beyond phase length.
REQ-025 req_valid held high continuously SHALL yield back-to-back transactions: new handshake in IDLE the cycle after DONE; minimum inter-transaction gap = DONE + IDLE cycle.
REQ-026 Changes on req_* while not in IDLE SHALL not affect the transaction in flight.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, counters=0, captured registers=0, bus_data_out=0, bus_data_out_valid=0, bus_mode=0, tx_done=0, req_ready=0.
REQ-028 req_ready SHALL rise on the first clock edge after rst_n deasserts (state IDLE).
REQ-029 Reset asserted mid-transaction SHALL abort immediately; no partial bits after release, no tx_done.

Configuration
REQ-030 Macro BUS_SERIAL_TX_PARITY_EN defined: after the last data bit, one extra cycle with bus_mode=1, bus_data_out_valid=1, bus_data_out = XOR of req_wdata (even parity), then DONE; write data phase = DATA_WIDTH+1 cycles.
REQ-031 Macro undefined: no parity bit, data phase exactly DATA_WIDTH cycles; read transactions unaffected in both cases.

Verification
REQ-032 Read req_addr=0x4001, req_write=0 -> 16 valid cycles mode 0, bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0; tx_done 17 cycles after handshake; no mode 1 cycle.
REQ-033 Write req_addr=0x8000, req_wdata=0xA5, TURN_CYCLES=1 -> 16 address bits (last =1), 1 invalid cycle, 8 data bits mode 1 = 1,0,1,0,0,1,0,1; tx_done next cycle (parity build: extra bit 0 before tx_done).
REQ-034 req_valid held high, two reads 0x0000 then 0x07FF -> second address phase starts exactly 2 cycles after first tx_done... i.e., DONE, IDLE handshake, then bits; req_ready=0 throughout first transaction.
REQ-035 rst_n pulsed low at address bit 7 -> all outputs 0 same cycle asynchronously, no tx_done; after release new request 0x1234 sends full 16 bits correctly.
REQ-036 TURN_CYCLES=0 write 0x4FFF/0xFF -> data bit 0 immediately follows address bit 15, bus_mode toggles 0->1 with no invalid cycle.
REQ-037 Changing req_addr/req_wdata every cycle during transfer -> serialized bits match values captured at handshake.
